// File: rtl/instr_rom_rv32i.sv
// Read-only instruction memory holding the fixed RV32I test program.
// A byte address on PC selects a 32-bit word, which appears on INSTR one cycle later.
module instr_rom_rv32i #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] INSTR
);

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       word_num;
  logic              out_of_range;
  logic [31:0]       rom_word;
  logic [31:0]       instr_d;

  // PC[1:0] is dropped, so a misaligned PC reads the word that contains it.
  assign word_idx = PC[ADDR_W+1:2];
  assign word_num = 32'(word_idx);

  // Fetches beyond the ROM return a NOP rather than aliasing back onto low words.
  assign out_of_range = (PC >= (32'(DEPTH) * 32'd4));

  // Constant program lookup; every unlisted entry reads as a NOP.
  always_comb begin
    rom_word = NOP_WORD;
    case (word_num)
      32'd0:   rom_word = 32'h00500093; // addi x1,x0,5
      32'd1:   rom_word = 32'h00A00113; // addi x2,x0,10
      32'd2:   rom_word = 32'h002081B3; // add  x3,x1,x2
      32'd3:   rom_word = 32'h40110233; // sub  x4,x2,x1
      32'd4:   rom_word = 32'h0020F2B3; // and  x5,x1,x2
      32'd5:   rom_word = 32'h0020E333; // or   x6,x1,x2
      32'd6:   rom_word = 32'h00302023; // sw   x3,0(x0)
      32'd7:   rom_word = 32'h00002383; // lw   x7,0(x0)
      32'd8:   rom_word = 32'h00718463; // beq  x3,x7,+8
      32'd9:   rom_word = 32'h00100413; // addi x8,x0,1 (skipped when branch taken)
      32'd10:  rom_word = 32'h00200413; // addi x8,x0,2
      32'd11:  rom_word = 32'h0000006F; // jal  x0,0 (halt loop)
      default: rom_word = NOP_WORD;
    endcase
  end

  // Next output word: NOP for out-of-range fetches, otherwise the ROM entry.
  always_comb begin
    instr_d = rom_word;
    if (out_of_range) begin
      instr_d = NOP_WORD;
    end
  end

  // Output register; synchronous reset loads the NOP.
  always_ff @(posedge clock) begin
    if (reset) begin
      INSTR <= NOP_WORD;
    end else begin
      INSTR <= instr_d;
    end
  end

endmodule

// File: tb/tb_instr_rom_rv32i.sv
// Directed self-checking bench for instr_rom_rv32i.
module tb_instr_rom_rv32i;

  logic        clock;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] INSTR;

  int errors;
  int checks;

  logic [31:0] exp_tbl [16] = '{
    32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40110233,
    32'h0020F2B3, 32'h0020E333, 32'h00302023, 32'h00002383,
    32'h00718463, 32'h00100413, 32'h00200413, 32'h0000006F,
    32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013
  };

  instr_rom_rv32i dut (
    .clock (clock),
    .reset (reset),
    .PC    (PC),
    .INSTR (INSTR)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    PC    = 32'h0;
    tick();
    checks++;
    if (INSTR !== 32'h00000013) begin
      errors++;
      $display("FAIL reset_edge1 got=%08h exp=%08h", INSTR, 32'h00000013);
    end
    tick();
    checks++;
    if (INSTR !== 32'h00000013) begin
      errors++;
      $display("FAIL reset_edge2 got=%08h exp=%08h", INSTR, 32'h00000013);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (INSTR !== 32'h00500093) begin
      errors++;
      $display("FAIL reset_release got=%08h exp=%08h", INSTR, 32'h00500093);
    end
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      PC = 32'(i) * 32'd4;
      tick();
      checks++;
      if (INSTR !== exp_tbl[i]) begin
        errors++;
        $display("FAIL seq_fetch pc=%08h got=%08h exp=%08h", PC, INSTR, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_hold();
    PC = 32'h08;
    tick();
    checks++;
    if (INSTR !== 32'h002081B3) begin
      errors++;
      $display("FAIL hold_first got=%08h exp=%08h", INSTR, 32'h002081B3);
    end
    PC = 32'h0C;
    #2;
    checks++;
    if (INSTR !== 32'h002081B3) begin
      errors++;
      $display("FAIL hold_midcycle got=%08h exp=%08h", INSTR, 32'h002081B3);
    end
    tick();
    checks++;
    if (INSTR !== 32'h40110233) begin
      errors++;
      $display("FAIL hold_next got=%08h exp=%08h", INSTR, 32'h40110233);
    end
  endtask

  task automatic test_misaligned();
    PC = 32'h0000000A;
    tick();
    checks++;
    if (INSTR !== 32'h002081B3) begin
      errors++;
      $display("FAIL misaligned_0a got=%08h exp=%08h", INSTR, 32'h002081B3);
    end
    PC = 32'h00000007;
    tick();
    checks++;
    if (INSTR !== 32'h00A00113) begin
      errors++;
      $display("FAIL misaligned_07 got=%08h exp=%08h", INSTR, 32'h00A00113);
    end
  endtask

  task automatic test_out_of_range();
    PC = 32'h00000100;
    tick();
    checks++;
    if (INSTR !== 32'h00000013) begin
      errors++;
      $display("FAIL oor_100 got=%08h exp=%08h", INSTR, 32'h00000013);
    end
    // Preload a non-NOP so a stale or aliased result cannot look correct.
    PC = 32'h0000002C;
    tick();
    checks++;
    if (INSTR !== 32'h0000006F) begin
      errors++;
      $display("FAIL last_prog_word got=%08h exp=%08h", INSTR, 32'h0000006F);
    end
    PC = 32'hFFFFFFFC;
    tick();
    checks++;
    if (INSTR !== 32'h00000013) begin
      errors++;
      $display("FAIL oor_fffffffc got=%08h exp=%08h", INSTR, 32'h00000013);
    end
    PC = 32'h00000004;
    tick();
    PC = 32'h00000104;
    tick();
    checks++;
    if (INSTR !== 32'h00000013) begin
      errors++;
      $display("FAIL oor_104_alias got=%08h exp=%08h", INSTR, 32'h00000013);
    end
    PC = 32'h000000FC;
    tick();
    checks++;
    if (INSTR !== 32'h00000013) begin
      errors++;
      $display("FAIL word63 got=%08h exp=%08h", INSTR, 32'h00000013);
    end
  endtask

  task automatic test_reset_mid();
    PC = 32'h1C;
    tick();
    checks++;
    if (INSTR !== 32'h00002383) begin
      errors++;
      $display("FAIL mid_pre got=%08h exp=%08h", INSTR, 32'h00002383);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (INSTR !== 32'h00000013) begin
      errors++;
      $display("FAIL mid_reset got=%08h exp=%08h", INSTR, 32'h00000013);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (INSTR !== 32'h00002383) begin
      errors++;
      $display("FAIL mid_release got=%08h exp=%08h", INSTR, 32'h00002383);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    PC     = 32'h0;
    #1;
    test_reset();
    test_sequential();
    test_hold();
    test_misaligned();
    test_out_of_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
